// File: rtl/sayac_pkg.sv
// Shared SAYAC definitions: controller state encoding and the default
// data/address width and memory wait timeout.
package sayac_pkg;

  localparam int unsigned SAYAC_N       = 16;
  localparam int unsigned SAYAC_TIMEOUT = 15;
  // Wide enough for any TIMEOUT in 1..255.
  localparam int unsigned SAYAC_CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } sayac_state_t;

endpackage

// File: rtl/sayac_wait_counter.sv
// Wait-cycle counter for the memory controller.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0 (dominates enable)
//   enable     : increment by one this cycle
//   tc         : high while the count equals TC_VALUE
module sayac_wait_counter #(
  parameter int unsigned W        = 8,
  parameter int unsigned TC_VALUE = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [W-1:0] TC = W'(TC_VALUE);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC);

endmodule

// File: rtl/sayac_mem_ctrl.sv
// SAYAC memory access controller. Accepts one CPU read or write request at a
// time, drives a registered address/data to memory, waits for readyMEM with a
// bounded timeout, and reports completion (selMem) or abandonment (timeoutErr).
//   clk, rst     : clock, asynchronous active-low reset
//   rdReq, wrReq : CPU requests, sampled only in IDLE (read wins on collision)
//   addrIn       : CPU address, dataIn : CPU write data
//   readyMEM     : memory completion strobe, dataMEM : memory read data
//   addrMEM      : registered memory address, dataOutMEM : registered write data
//   readMEM      : high while in READ, writeMEM : high while in WRITE
//   rdData       : captured read data (write-back mux in1)
//   selMem       : one-cycle pulse after a completed read (write-back mux sel1)
//   busy         : high whenever not IDLE
//   timeoutErr   : one-cycle pulse when an access is abandoned
module sayac_mem_ctrl
  import sayac_pkg::*;
#(
  parameter int unsigned N       = SAYAC_N,
  parameter int unsigned TIMEOUT = SAYAC_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdReq,
  input  logic         wrReq,
  input  logic [N-1:0] addrIn,
  input  logic [N-1:0] dataIn,
  input  logic         readyMEM,
  input  logic [N-1:0] dataMEM,
  output logic [N-1:0] addrMEM,
  output logic [N-1:0] dataOutMEM,
  output logic         readMEM,
  output logic         writeMEM,
  output logic [N-1:0] rdData,
  output logic         selMem,
  output logic         busy,
  output logic         timeoutErr
);

  sayac_state_t state, state_nx;
  logic         op_rd;     // last accepted access was a read
  logic         in_access;
  logic         wait_tc;
  logic         accept;

  assign in_access = (state == READ) || (state == WRITE);
  assign accept    = (state == IDLE) && (rdReq || wrReq);

  // Terminal count is one below TIMEOUT: the cycle in which the counter would
  // reach TIMEOUT is the last one in which readyMEM can still complete.
  sayac_wait_counter #(
    .W        (SAYAC_CNT_W),
    .TC_VALUE (TIMEOUT - 1)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_access),
    .enable (in_access && !readyMEM),
    .tc     (wait_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rdReq) begin
          state_nx = READ;
        end else if (wrReq) begin
          state_nx = WRITE;
        end
      end
      READ, WRITE: begin
        if (readyMEM) begin
          state_nx = DONE;
        end else if (wait_tc) begin
          state_nx = ERR;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    readMEM    = 1'b0;
    writeMEM   = 1'b0;
    selMem     = 1'b0;
    timeoutErr = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      READ:    readMEM    = 1'b1;
      WRITE:   writeMEM   = 1'b1;
      DONE:    selMem     = op_rd;
      ERR:     timeoutErr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrMEM    <= '0;
      dataOutMEM <= '0;
      op_rd      <= 1'b0;
      rdData     <= '0;
    end else begin
      if (accept) begin
        addrMEM    <= addrIn;
        dataOutMEM <= dataIn;
        op_rd      <= rdReq;
      end
      if ((state == READ) && readyMEM) begin
        rdData <= dataMEM;
      end
    end
  end

endmodule

// File: tb/tb_sayac_mem_ctrl.sv
module tb_sayac_mem_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdReq, wrReq, readyMEM;
  logic [N-1:0] addrIn, dataIn, dataMEM;
  logic [N-1:0] addrMEM, dataOutMEM, rdData;
  logic         readMEM, writeMEM, selMem, busy, timeoutErr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last successfully read data.
  logic [N-1:0] exp_rd;

  sayac_mem_ctrl #(.N(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdReq      (rdReq),
    .wrReq      (wrReq),
    .addrIn     (addrIn),
    .dataIn     (dataIn),
    .readyMEM   (readyMEM),
    .dataMEM    (dataMEM),
    .addrMEM    (addrMEM),
    .dataOutMEM (dataOutMEM),
    .readMEM    (readMEM),
    .writeMEM   (writeMEM),
    .rdData     (rdData),
    .selMem     (selMem),
    .busy       (busy),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [N-1:0] a, input logic [N-1:0] d);
    check({tag, ".busy"},  32'(busy), 32'd0);
    check({tag, ".rd"},    32'(readMEM), 32'd0);
    check({tag, ".wr"},    32'(writeMEM), 32'd0);
    check({tag, ".sel"},   32'(selMem), 32'd0);
    check({tag, ".terr"},  32'(timeoutErr), 32'd0);
    check({tag, ".rdata"}, 32'(rdData), 32'(exp_rd));
    check({tag, ".addr"},  32'(addrMEM), 32'(a));
    check({tag, ".dout"},  32'(dataOutMEM), 32'(d));
  endtask

  // One complete access. ready_at = 1-based access cycle in which readyMEM is
  // raised; values above TO mean memory never answers. Requests and readyMEM
  // are randomly toggled where the controller must ignore them.
  task automatic run_txn(input bit rd, input bit wr, input logic [N-1:0] a,
                         input logic [N-1:0] d, input logic [N-1:0] m,
                         input int ready_at);
    bit is_read;
    int len;
    is_read  = rd;
    len      = (ready_at <= int'(TO)) ? ready_at : int'(TO);
    rdReq    = rd;
    wrReq    = wr;
    addrIn   = a;
    dataIn   = d;
    readyMEM = 1'($urandom);
    dataMEM  = N'($urandom);
    step();
    for (int k = 1; k <= len; k++) begin
      check("acc.rd",   32'(readMEM), 32'(is_read));
      check("acc.wr",   32'(writeMEM), 32'(!is_read));
      check("acc.busy", 32'(busy), 32'd1);
      check("acc.sel",  32'(selMem), 32'd0);
      check("acc.terr", 32'(timeoutErr), 32'd0);
      check("acc.addr", 32'(addrMEM), 32'(a));
      check("acc.dout", 32'(dataOutMEM), 32'(d));
      rdReq    = 1'($urandom);
      wrReq    = 1'($urandom);
      addrIn   = N'($urandom);
      dataIn   = N'($urandom);
      readyMEM = (k == ready_at);
      dataMEM  = (k == ready_at) ? m : N'($urandom);
      step();
    end
    if (ready_at <= int'(TO)) begin
      if (is_read) exp_rd = m;
      check("done.sel",  32'(selMem), 32'(is_read));
      check("done.terr", 32'(timeoutErr), 32'd0);
      check("done.busy", 32'(busy), 32'd1);
    end else begin
      check("err.terr", 32'(timeoutErr), 32'd1);
      check("err.sel",  32'(selMem), 32'd0);
      check("err.busy", 32'(busy), 32'd1);
    end
    check("end.rd",    32'(readMEM), 32'd0);
    check("end.wr",    32'(writeMEM), 32'd0);
    check("end.rdata", 32'(rdData), 32'(exp_rd));
    rdReq    = 1'($urandom);
    wrReq    = 1'($urandom);
    readyMEM = 1'($urandom);
    step();
    check_quiet("post", a, is_read ? d : d);
    rdReq = 1'b0;
    wrReq = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic [N-1:0] a, input logic [N-1:0] d);
    rdReq = 1'b0;
    wrReq = 1'b0;
    for (int i = 0; i < n; i++) begin
      readyMEM = 1'($urandom);
      dataMEM  = N'($urandom);
      step();
      check_quiet("idle", a, d);
    end
  endtask

  initial begin
    logic [N-1:0] ra, rdv, rm;
    int           rr;
    bit           r_rd, r_wr;

    rst = 1'b0; rdReq = 1'b0; wrReq = 1'b0; readyMEM = 1'b0;
    addrIn = '0; dataIn = '0; dataMEM = '0;
    exp_rd = '0;
    #2;
    check_quiet("reset", '0, '0);
    #10 rst = 1'b1;
    step();
    idle_cycles(2, '0, '0);

    // Read, memory answers on the 3rd READ cycle.
    run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3);
    // Write, answered after 1 cycle.
    run_txn(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h5555, 1);
    // Timeout on a read: rdData must keep 0xBEEF.
    run_txn(1'b1, 1'b0, 16'h0022, 16'h0033, 16'hDEAD, int'(TO) + 1);
    // Collision: read wins.
    run_txn(1'b1, 1'b1, 16'h0077, 16'h0088, 16'hCAFE, 2);
    // Boundary: readyMEM in the last allowed cycle completes.
    run_txn(1'b1, 1'b0, 16'h0101, 16'h0202, 16'hA5A5, int'(TO));
    // Boundary on write timeout.
    run_txn(1'b0, 1'b1, 16'h0303, 16'h0404, 16'h0000, int'(TO) + 1);
    idle_cycles(2, 16'h0303, 16'h0404);

    // Randomized accesses.
    for (int t = 0; t < 40; t++) begin
      ra  = N'($urandom);
      rdv = N'($urandom);
      rm  = N'($urandom);
      r_rd = 1'($urandom);
      r_wr = r_rd ? 1'($urandom) : 1'b1;
      rr  = int'($urandom_range(1, TO + 3));
      run_txn(r_rd, r_wr, ra, rdv, rm, rr);
      if ($urandom_range(0, 3) == 0) idle_cycles(1, ra, rdv);
    end

    // Asynchronous reset in the middle of a read.
    rdReq = 1'b1; addrIn = 16'h0555; dataIn = 16'h0666; readyMEM = 1'b0;
    step();
    rdReq = 1'b0;
    check("mid.rd", 32'(readMEM), 32'd1);
    step();
    #2 rst = 1'b0;
    #1;
    exp_rd = '0;
    check_quiet("async_rst", '0, '0);
    step();
    check_quiet("rst_hold", '0, '0);
    rst = 1'b1;
    idle_cycles(TO + 2, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sayac_mem_ctrl.md
SAYAC_MEM_CTRL -- requirements
Module: sayac_mem_ctrl

Interface
REQ-001 The module SHALL have parameter N, default 16, giving the data and address width in bits.
REQ-002 The module SHALL have parameter TIMEOUT, default 15, giving the maximum wait cycles for readyMEM (range 1..255).
REQ-003 Port clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port rdReq  input  1  CPU read request, sampled in IDLE only.
REQ-006 Port wrReq  input  1  CPU write request, sampled in IDLE only.
REQ-007 Port addrIn  input  N  CPU address.
REQ-008 Port dataIn  input  N  CPU write data.
REQ-009 Port readyMEM  input  1  memory completion strobe.
REQ-010 Port dataMEM  input  N  memory read data, valid when readyMEM=1.
REQ-011 Port addrMEM  output  N  registered address to memory.
REQ-012 Port dataOutMEM  output  N  registered write data to memory.
REQ-013 Port readMEM  output  1  memory read strobe.
REQ-014 Port writeMEM  output  1  memory write strobe.
REQ-015 Port rdData  output  N  captured read data; drives the write-back mux in1.
REQ-016 Port selMem  output  1  one-cycle valid pulse; drives the write-back mux sel1.
REQ-017 Port busy  output  1  high whenever the state is not IDLE.
REQ-018 Port timeoutErr  output  1  one-cycle pulse on an abandoned access.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WRITE, DONE and ERR.
REQ-020 In IDLE, rdReq=1 SHALL transition to READ; if rdReq=1 and wrReq=1 together, read SHALL win and wrReq is dropped.
REQ-021 In IDLE, wrReq=1 with rdReq=0 SHALL transition to WRITE.
REQ-022 On IDLE exit, addrIn SHALL be latched into addrMEM and dataIn into dataOutMEM; both SHALL hold until the next IDLE exit.
REQ-023 readMEM SHALL equal 1 exactly while in READ, and writeMEM exactly while in WRITE (Moore outputs).
REQ-024 In READ or WRITE, the wait counter SHALL reset to 0 on entry and increment every cycle with readyMEM=0.
REQ-025 In READ with readyMEM=1, dataMEM SHALL be captured into rdData and the FSM SHALL move to DONE.
REQ-026 In WRITE with readyMEM=1, the FSM SHALL move to DONE; rdData SHALL be unchanged.
REQ-027 If the counter reaches TIMEOUT with readyMEM still 0, the FSM SHALL move to ERR.
REQ-028 readyMEM=1 in the same cycle the counter reaches TIMEOUT SHALL take precedence (complete, not ERR).
REQ-029 DONE SHALL last one cycle, then return to IDLE; selMem SHALL be 1 only in DONE reached from READ.
REQ-030 ERR SHALL last one cycle with timeoutErr=1, then return to IDLE; rdData SHALL keep its prior value.
REQ-031 Requests while busy=1 SHALL be ignored, not queued.
REQ-032 Read latency: a request sampled at edge 0 with readyMEM=1 at edge 1 SHALL give selMem=1 and valid rdData after edge 2.
REQ-033 readyMEM in IDLE, DONE or ERR SHALL be ignored.

Reset
REQ-034 rst=0 SHALL immediately force state IDLE, counter 0, addrMEM, dataOutMEM and rdData to 0, and readMEM, writeMEM, selMem, busy and timeoutErr to 0.
REQ-035 Reset during READ or WRITE SHALL abandon the access without a selMem or timeoutErr pulse.

Structure
REQ-036 The state encoding and the default N and TIMEOUT constants SHALL live in the shared SAYAC package.
REQ-037 The wait counter SHALL be a sub-module named sayac_wait_counter (clear, enable, terminal-count output); everything else stays flat.

Verification
REQ-038 Read: rdReq=1, addrIn=0x0040, readyMEM=1 on the 3rd READ cycle with dataMEM=0xBEEF -> readMEM high 3 cycles, then rdData=0xBEEF and selMem=1 for exactly one cycle.
REQ-039 Write: wrReq=1, addrIn=0x0010, dataIn=0x1234, readyMEM=1 after 1 cycle -> writeMEM high 1 cycle, addrMEM=0x0010, dataOutMEM=0x1234, selMem stays 0.
REQ-040 Timeout: rdReq=1, readyMEM held 0 -> ERR after 15 wait cycles, timeoutErr one-cycle pulse, rdData unchanged, busy=0 the next cycle.
REQ-041 Collision: rdReq=1 and wrReq=1 in the same cycle -> READ entered and writeMEM never asserted; a second rdReq while busy produces no second access.
REQ-042 Boundary: readyMEM=1 in the same cycle the counter hits TIMEOUT -> DONE, selMem=1, timeoutErr=0.
REQ-043 Reset: rst=0 mid-READ -> all outputs 0 immediately (asynchronously), state IDLE, no pulses after release.
